// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: memory request/response structs,
// their reset values, and the per-channel arbitration state.
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

   localparam int mem_arb_max_req = 16;
   localparam int MEM_AW = 32;
   localparam int MEM_DW = 32;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_t;

   typedef struct packed {
      logic              en;
      logic [MEM_AW-1:0] addr;
   } mem_read_req_t;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic [MEM_DW-1:0] data;
   } mem_read_rsp_t;

   typedef struct packed {
      logic                en;
      logic [MEM_AW-1:0]   addr;
      logic [MEM_DW-1:0]   data;
      logic [MEM_DW/8-1:0] strb;
   } mem_write_req_t;

   typedef struct packed {
      logic valid;
      logic done;
   } mem_write_rsp_t;

   localparam mem_read_req_t  mem_read_req_rst  = '0;
   localparam mem_read_rsp_t  mem_read_rsp_rst  = '0;
   localparam mem_write_req_t mem_write_req_rst = '0;
   localparam mem_write_rsp_t mem_write_rsp_rst = '0;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin pick: first requesting index after ptr, with wrap.
`timescale 1ns/1ps
module mem_arb_rr_pick #(
   parameter  int req_cnt = 4,
   localparam int IDX_W   = $clog2(req_cnt)
) (
   input  logic [req_cnt-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   // Walk from the farthest candidate inward so the nearest one after ptr wins.
   always_comb begin
      idx = ptr;
      any = 1'b0;
      for (int i = req_cnt; i >= 1; i--) begin
         int cand;
         cand = (int'(ptr) + i) % req_cnt;
         if (req[cand]) begin
            idx = IDX_W'(cand);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory read port and one write port among req_cnt
// requesters. Define MEM_PORT_ARB_TIMEOUT_EN to build the per-grant watchdog.
`timescale 1ns/1ps
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter  int req_cnt        = 4,
   parameter  int timeout_cycles = 16,
   localparam int IDX_W          = $clog2(req_cnt)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  mem_read_req_t  cl_read_req  [req_cnt],
   output mem_read_rsp_t  cl_read_rsp  [req_cnt],
   input  mem_write_req_t cl_write_req [req_cnt],
   output mem_write_rsp_t cl_write_rsp [req_cnt],
   output mem_read_req_t  mem_read_req,
   input  mem_read_rsp_t  mem_read_rsp,
   output mem_write_req_t mem_write_req,
   input  mem_write_rsp_t mem_write_rsp,
   output logic [IDX_W-1:0] read_owner,
   output logic [IDX_W-1:0] write_owner,
   output logic           read_busy,
   output logic           write_busy,
   output logic [1:0]     timeout_err
);

   arb_state_t       rd_state_q, rd_state_d, wr_state_q, wr_state_d;
   logic [IDX_W-1:0] rd_owner_q, rd_owner_d, rd_ptr_q, rd_ptr_d, rd_pick;
   logic [IDX_W-1:0] wr_owner_q, wr_owner_d, wr_ptr_q, wr_ptr_d, wr_pick;
   logic [req_cnt-1:0] rd_req_vec, wr_req_vec;
   logic             rd_any, wr_any, rd_release, wr_release, rd_to, wr_to;
   mem_read_req_t    rd_sel_req;
   mem_write_req_t   wr_sel_req;

   always_comb begin
      rd_sel_req = cl_read_req[0];
      wr_sel_req = cl_write_req[0];
      for (int i = 0; i < req_cnt; i++) begin
         rd_req_vec[i] = cl_read_req[i].en;
         wr_req_vec[i] = cl_write_req[i].en;
         if (rd_owner_q == IDX_W'(i)) rd_sel_req = cl_read_req[i];
         if (wr_owner_q == IDX_W'(i)) wr_sel_req = cl_write_req[i];
      end
   end

   mem_arb_rr_pick #(.req_cnt(req_cnt)) u_rd_pick (
      .req (rd_req_vec),
      .ptr (rd_ptr_q),
      .idx (rd_pick),
      .any (rd_any)
   );

   mem_arb_rr_pick #(.req_cnt(req_cnt)) u_wr_pick (
      .req (wr_req_vec),
      .ptr (wr_ptr_q),
      .idx (wr_pick),
      .any (wr_any)
   );

   // Done, invalid address (valid low) or withdrawal all end the grant.
   assign rd_release = !mem_read_rsp.valid  || mem_read_rsp.done  || !rd_sel_req.en;
   assign wr_release = !mem_write_rsp.valid || mem_write_rsp.done || !wr_sel_req.en;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(timeout_cycles + 1);
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

   always_comb begin
      rd_cnt_d = (rd_state_q == ARB_BUSY) ? rd_cnt_q + 1'b1 : '0;
      wr_cnt_d = (wr_state_q == ARB_BUSY) ? wr_cnt_q + 1'b1 : '0;
      rd_to = en && (rd_state_q == ARB_BUSY) && !rd_release &&
              (rd_cnt_q == CNT_W'(timeout_cycles - 1));
      wr_to = en && (wr_state_q == ARB_BUSY) && !wr_release &&
              (wr_cnt_q == CNT_W'(timeout_cycles - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (en) begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end
`else
   assign rd_to = 1'b0;
   assign wr_to = 1'b0;
`endif

   always_comb begin
      rd_state_d = rd_state_q;
      rd_owner_d = rd_owner_q;
      rd_ptr_d   = rd_ptr_q;
      case (rd_state_q)
         ARB_IDLE: if (rd_any) begin
            rd_state_d = ARB_BUSY;
            rd_owner_d = rd_pick;
         end
         ARB_BUSY: if (rd_release || rd_to) begin
            rd_state_d = ARB_IDLE;
            rd_ptr_d   = rd_owner_q;
         end
         default: rd_state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      wr_state_d = wr_state_q;
      wr_owner_d = wr_owner_q;
      wr_ptr_d   = wr_ptr_q;
      case (wr_state_q)
         ARB_IDLE: if (wr_any) begin
            wr_state_d = ARB_BUSY;
            wr_owner_d = wr_pick;
         end
         ARB_BUSY: if (wr_release || wr_to) begin
            wr_state_d = ARB_IDLE;
            wr_ptr_d   = wr_owner_q;
         end
         default: wr_state_d = ARB_IDLE;
      endcase
   end

   // Pointer resets to the last index so requester 0 is served first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_state_q <= ARB_IDLE;
         rd_owner_q <= '0;
         rd_ptr_q   <= IDX_W'(req_cnt - 1);
         wr_state_q <= ARB_IDLE;
         wr_owner_q <= '0;
         wr_ptr_q   <= IDX_W'(req_cnt - 1);
      end else if (en) begin
         rd_state_q <= rd_state_d;
         rd_owner_q <= rd_owner_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_state_q <= wr_state_d;
         wr_owner_q <= wr_owner_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_comb begin
      mem_read_req  = mem_read_req_rst;
      mem_write_req = mem_write_req_rst;
      for (int i = 0; i < req_cnt; i++) begin
         cl_read_rsp[i]  = mem_read_rsp_rst;
         cl_write_rsp[i] = mem_write_rsp_rst;
      end
      if (rd_state_q == ARB_BUSY) begin
         mem_read_req = rd_sel_req;
         for (int i = 0; i < req_cnt; i++) begin
            if (rd_owner_q == IDX_W'(i)) begin
               cl_read_rsp[i] = mem_read_rsp;
               if (rd_to) cl_read_rsp[i].valid = 1'b0;
            end
         end
      end
      if (wr_state_q == ARB_BUSY) begin
         mem_write_req = wr_sel_req;
         for (int i = 0; i < req_cnt; i++) begin
            if (wr_owner_q == IDX_W'(i)) begin
               cl_write_rsp[i] = mem_write_rsp;
               if (wr_to) cl_write_rsp[i].valid = 1'b0;
            end
         end
      end
   end

   assign read_owner  = rd_owner_q;
   assign write_owner = wr_owner_q;
   assign read_busy   = (rd_state_q == ARB_BUSY);
   assign write_busy  = (wr_state_q == ARB_BUSY);
   assign timeout_err = {wr_to, rd_to};

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory read port and one memory write port among req_cnt requesters, for example the parallel fetch/LSU branches.
- Read and write channels are arbitrated independently, each round-robin.
- The grant is held from acceptance until the memory reports done, reports invalid, or the requester withdraws.
- Sits between the core-side requesters and one read/write port pair of the memory block.

Parameters:
- req_cnt, 4, number of requesters; must be 2..16.
- timeout_cycles, 16, watchdog limit in cycles per grant; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when low, state and counters freeze.
- cl_read_req  in  sys::mem_read_req_t[req_cnt]  requester read requests.
- cl_read_rsp  out  sys::mem_read_rsp_t[req_cnt]  requester read responses.
- cl_write_req  in  sys::mem_write_req_t[req_cnt]  requester write requests.
- cl_write_rsp  out  sys::mem_write_rsp_t[req_cnt]  requester write responses.
- mem_read_req  out  sys::mem_read_req_t  to the memory read port.
- mem_read_rsp  in  sys::mem_read_rsp_t  from the memory read port.
- mem_write_req  out  sys::mem_write_req_t  to the memory write port.
- mem_write_rsp  in  sys::mem_write_rsp_t  from the memory write port.
- read_owner, write_owner  out  $clog2(req_cnt)  current grant holder; valid only while busy.
- read_busy, write_busy  out  1  channel is in the BUSY state.
- timeout_err  out  2  one-cycle pulse; bit0 = read channel, bit1 = write channel.

Behaviour:
- Reset (rst=0, asynchronous):
  - Both channels go to IDLE; round-robin pointer = req_cnt-1, so requester 0 wins first.
  - owner = 0, busy = 0, timeout_err = 0.
  - mem_*_req = sys::mem_*_req_rst; all cl_*_rsp = sys::mem_*_rsp_rst.
- Each channel has two states, IDLE and BUSY. The two channels never interact.
- IDLE:
  - mem_*_req = rst value (en=0).
  - If any cl_*_req[i].en is set, at the next edge: owner = first requesting index after the pointer, with wrap-around; go to BUSY.
- BUSY:
  - mem_*_req = cl_*_req[owner], combinational pass-through.
  - cl_*_rsp[owner] = mem_*_rsp, combinational.
  - All non-owners see the rst response (valid=0, done=0).
- Release conditions, evaluated at the edge; each returns the channel to IDLE and sets pointer = owner:
  - mem_*_rsp.valid && done (normal completion).
  - !mem_*_rsp.valid: out-of-range or misaligned address. The owner sees valid=0 for that one cycle.
  - cl_*_req[owner].en == 0: requester withdrew. Nothing reaches memory after release.
- Latency with an idle memory:
  - Request at cycle 0 → grant at the cycle-1 edge.
  - Memory acks at the cycle-2 edge → done visible to the requester in cycle 2.
  - Back to IDLE at the cycle-3 edge.
  - Minimum 3 cycles per grant. One IDLE bubble always separates grants, so the downstream en drops between owners.
- Requesters must hold a request stable until done; changing fields mid-grant is forwarded unchanged.
- All requesters waiting: grants rotate strictly. No requester waits more than req_cnt-1 grants.
- Simultaneous read and write to the same address from different owners: forwarded as-is. The memory's read-after-write done gating resolves ordering.
- en=0: state, pointer, owner and counter hold; outputs remain combinational from the held state.
- Reset mid-BUSY: immediate IDLE; the in-flight transaction is dropped and never reported done.

Optional Feature:
- Macro: MEM_PORT_ARB_TIMEOUT_EN.
- Defined:
  - Per-channel counter, $clog2(timeout_cycles+1) bits, cleared on entering BUSY and incremented every enabled BUSY cycle.
  - When the counter reaches timeout_cycles without a release: force IDLE, advance the pointer, pulse timeout_err[ch] for one cycle.
  - The owner sees valid=0 in the cycle the timeout is taken.
- Undefined: no counter is built, timeout_err is tied to 0, and grants may be held indefinitely.

Decomposition:
- sys package additions:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}.
  - constant mem_arb_max_req = 16.
- Sub-module mem_arb_rr_pick:
  - Combinational round-robin pick: request vector + pointer → index and any-valid flag.
  - Instantiated once per channel.
- Channel FSMs are written inline, twice, because the request/response types differ.

Test Plan:
- Single read: req_cnt=4; requester 2 reads addr 0x10 with mem done → grant at edge 1, read_owner=2, cl_read_rsp[2].done in cycle 2, read_busy=0 after edge 3; other responses stay 0.
- Round-robin: requesters 0,1,3 hold reads continuously → grant order 0,1,3,0,1,3 with one IDLE cycle between grants; requester 2 never granted.
- Invalid address: requester 1 writes addr 0x3 (misaligned) → cl_write_rsp[1].valid=0, channel IDLE next edge, no memory write occurs.
- Read/write concurrency: requester 0 reads and requester 1 writes addr 0x20 together → both channels BUSY in the same cycle with owners 0 and 1; read done only after the write is done.
- Withdrawal and reset: requester 3 drops en in the BUSY cycle → IDLE next edge, pointer=3. Separately, rst=0 mid-BUSY → busy=0 and mem_*_req.en=0 immediately, with no clock edge needed.
- With MEM_PORT_ARB_TIMEOUT_EN and timeout_cycles=4: memory held not-done → timeout_err[0] pulses at the 4th BUSY cycle and the next requester is granted.
